// File: rtl/spi_flash_reader_if.sv
// spi_flash_reader_if: request/stream port between the frame-data generator and the flash reader
interface spi_flash_reader_if;
  logic [23:0] addr;
  logic [15:0] len;
  logic go;
  logic rdy;
  logic [7:0] data;
  logic valid;
  modport master (output addr, len, go, input rdy, data, valid);
  modport slave (input addr, len, go, output rdy, data, valid);
endinterface

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI NOR read master (mode 0, clk/2), one byte-strobe per received byte.
// Define SPI_FLASH_FAST_READ_EN for the fast-read opcode with 8 dummy bit periods.
module spi_flash_reader #(
  parameter logic [7:0] CMD_READ = 8'h03,
  parameter logic [7:0] CMD_FAST_READ = 8'h0B,
  parameter int CS_HIGH_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  spi_flash_reader_if.slave sr,
  output logic spi_cs_n,
  output logic spi_clk,
  output logic spi_mosi,
  input logic spi_miso
);
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE = CMD_FAST_READ;
  localparam bit FAST = 1'b1;
`else
  localparam logic [7:0] OPCODE = CMD_READ;
  localparam bit FAST = 1'b0;
`endif
  localparam int GW = CS_HIGH_CYCLES > 1 ? $clog2(CS_HIGH_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, GAP} state_t;
  state_t state;
  logic ph, emit;
  logic [4:0] bc;
  logic [30:0] tx;
  logic [15:0] rx, len_q;
  logic [16:0] nb;
  logic [GW-1:0] gc;
  // Each byte is released one byte-period late (after the next byte has been clocked in),
  // so the last byte's strobe coincides with the end of the final bit period and cs_n rising.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ph <= 1'b0;
      emit <= 1'b0;
      bc <= '0;
      tx <= '0;
      rx <= '0;
      len_q <= '0;
      nb <= '0;
      gc <= '0;
      sr.rdy <= 1'b1;
      sr.valid <= 1'b0;
      sr.data <= 8'h00;
      spi_cs_n <= 1'b1;
      spi_clk <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      sr.valid <= 1'b0;
      if (state == IDLE) begin
        if (sr.go) begin
          state <= CMD;
          sr.rdy <= 1'b0;
          spi_cs_n <= 1'b0;
          spi_mosi <= OPCODE[7];
          tx <= {OPCODE[6:0], sr.addr};
          len_q <= sr.len;
          ph <= 1'b0;
          emit <= 1'b0;
          bc <= '0;
          nb <= '0;
        end
      end else if (state == GAP) begin
        if (gc == '0) begin
          state <= IDLE;
          sr.rdy <= 1'b1;
        end else gc <= gc - 1'b1;
      end else if (!ph) begin
        if (emit) begin
          sr.data <= rx[15:8];
          sr.valid <= 1'b1;
          emit <= 1'b0;
        end
        if (emit && nb == {1'b0, len_q} + 17'd2) begin
          state <= GAP;
          spi_cs_n <= 1'b1;
          gc <= GW'(CS_HIGH_CYCLES - 1);
        end else begin
          spi_clk <= 1'b1;
          ph <= 1'b1;
        end
      end else begin
        spi_clk <= 1'b0;
        ph <= 1'b0;
        bc <= bc + 1'b1;
        tx <= {tx[29:0], 1'b0};
        spi_mosi <= tx[30];
        if (state == DATA) begin
          rx <= {rx[14:0], spi_miso};
          if (bc[2:0] == 3'd7) begin
            nb <= nb + 17'd1;
            emit <= nb != '0;
          end
        end
        if (state == CMD && bc == 5'd7) begin
          state <= ADDR;
          bc <= '0;
        end
        if (state == ADDR && bc == 5'd23) begin
          state <= FAST ? DUMMY : DATA;
          bc <= '0;
        end
        if (state == DUMMY && bc == 5'd7) begin
          state <= DATA;
          bc <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: random and directed reads against a behavioural SPI flash and timing model
module tb_spi_flash_reader;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam int LAT = 113, HDR = 40;
  localparam logic [7:0] OPC = 8'h0B;
`else
  localparam int LAT = 97, HDR = 32;
  localparam logic [7:0] OPC = 8'h03;
`endif
  localparam int CS = 2;
  logic clk = 1'b0, rst_n = 1'b0, spi_miso = 1'b0;
  logic spi_cs_n, spi_clk, spi_mosi;
  int cyc = 0, n_cmp = 0, n_err = 0;
  spi_flash_reader_if sr();
  spi_flash_reader #(.CS_HIGH_CYCLES(CS)) dut (
    .clk(clk), .rst_n(rst_n), .sr(sr),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] mem(input logic [23:0] a);
    return a[7:0] ^ a[15:8];
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  // Flash: latch opcode and address on spi_clk rises, shift data out on falls after the header
  logic [7:0] f_cmd = 8'h00, f_byte;
  logic [23:0] f_addr = 24'h0;
  logic pclk = 1'b0;
  int f_bits = 0, f_out = 0, f_bad = 0;
  always @(spi_clk or negedge spi_cs_n) begin
    if (spi_clk !== pclk) begin
      pclk = spi_clk;
      if (!spi_cs_n && spi_clk) begin
        if (f_bits < 8) f_cmd = {f_cmd[6:0], spi_mosi};
        else if (f_bits < 32) f_addr = {f_addr[22:0], spi_mosi};
        else if (spi_mosi) f_bad++;
        f_bits++;
      end else if (!spi_cs_n && !spi_clk && f_bits >= HDR) begin
        f_byte = mem(f_addr + 24'(f_out / 8));
        spi_miso = f_byte[7 - f_out % 8];
        f_out++;
      end
    end else if (!spi_cs_n) begin
      f_bits = 0;
      f_out = 0;
      f_bad = 0;
      f_cmd = 8'h00;
      f_addr = 24'h0;
    end
  end
  task automatic wait_rdy();
    int t = 0;
    while (!sr.rdy && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("rdy_wait", 32'(sr.rdy), 32'd1);
  endtask
  task automatic xfer(input logic [23:0] a, input logic [15:0] l, input bit poke);
    int e0, lim, n = 0, cs_up = -1, rdy_up = -1, rise = -1;
    wait_rdy();
    sr.addr = a;
    sr.len = l;
    sr.go = 1'b1;
    @(negedge clk);
    e0 = cyc;
    sr.go = 1'b0;
    sr.addr = 24'($urandom);
    sr.len = 16'($urandom);
    check("start", 32'({sr.rdy, spi_cs_n}), 32'd0);
    lim = LAT + 16 * (int'(l) + 1) + CS + 8;
    for (int i = 0; i < lim && rdy_up < 0; i++) begin
      sr.go = poke && cyc == e0 + 30;
      if (spi_clk && rise < 0) rise = cyc;
      if (sr.valid) begin
        check("v_time", cyc, e0 + LAT + 16 * n);
        check("v_data", 32'(sr.data), 32'(mem(a + 24'(n))));
        n++;
      end
      if (spi_cs_n && cs_up < 0) cs_up = cyc;
      if (sr.rdy) rdy_up = cyc;
      @(negedge clk);
    end
    sr.go = 1'b0;
    check("n_bytes", n, int'(l) + 1);
    check("first_rise", rise, e0 + 1);
    check("cs_up", cs_up, e0 + LAT + 16 * int'(l));
    check("rdy_up", rdy_up, cs_up + CS);
    check("opcode", 32'(f_cmd), 32'(OPC));
    check("addr", 32'(f_addr), 32'(a));
    check("mosi_zero", f_bad, 0);
  endtask
  task automatic b2b();
    int hi = 0, nv = 0, t = 0, st = 0;
    wait_rdy();
    sr.addr = 24'h000200;
    sr.len = 16'd0;
    sr.go = 1'b1;
    while (t < 400 && !(st == 3 && nv == 2)) begin
      @(negedge clk);
      t++;
      if (sr.valid) begin
        check("b2b_data", 32'(sr.data), 32'(mem(24'h000200)));
        nv++;
      end
      if (!spi_cs_n && st == 2) begin
        check("cs_gap", hi, CS + 1);
        st = 3;
        sr.go = 1'b0;
      end
      if (spi_cs_n && st == 1) st = 2;
      if (spi_cs_n && st == 2) hi++;
      if (!spi_cs_n && st == 0) st = 1;
    end
    sr.go = 1'b0;
    check("b2b_seq", st, 3);
    check("b2b_nv", nv, 2);
  endtask
  task automatic rst_mid();
    int n = 0, t = 0;
    wait_rdy();
    sr.addr = 24'h040000;
    sr.len = 16'd127;
    sr.go = 1'b1;
    @(negedge clk);
    sr.go = 1'b0;
    while (n < 41 && t < 1200) begin
      @(negedge clk);
      t++;
      if (sr.valid) n++;
    end
    check("rst_reach", n, 41);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 32'({spi_cs_n, sr.valid, sr.rdy, spi_clk, spi_mosi}), 32'b10100);
    @(negedge clk);
    check("rst_hold", 32'({spi_cs_n, sr.valid, sr.rdy}), 32'b101);
    rst_n = 1'b1;
    xfer(24'h000100, 16'($urandom_range(1, 20)), 1'b0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    sr.go = 1'b0;
    sr.addr = '0;
    sr.len = '0;
    #12 check("rst_vals", 32'({sr.rdy, sr.valid, sr.data, spi_cs_n, spi_clk, spi_mosi}),
                  32'({1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle", 32'({sr.rdy, spi_cs_n, spi_clk, sr.valid}), 32'b1100);
    end
    xfer(24'h040000, 16'd127, 1'b1);
    xfer(24'h123456, 16'd0, 1'b0);
    b2b();
    for (int i = 0; i < 6; i++)
      xfer(24'($urandom), 16'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
    xfer(24'hFFFFFE, 16'd3, 1'b0);
    rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
